// File: rtl/seg_scan_if.sv
// Write-side handshake for the seven-segment scan controller.
// The source offers a display value and blank mask; the controller accepts it when ready.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [4*DIGITS-1:0]   wr_data;
    logic [DIGITS-1:0]     wr_blank;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_blank,
        output wr_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-cathode seven-segment digits.
// Values are double-buffered and swapped in only at frame boundaries.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int DEAD   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    seg_scan_if.slave         wr,
    output logic [3:0]        nib_out,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_start
);
    localparam int SW = $clog2(DIV);
    localparam int DW = $clog2(DIGITS);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [4*DIGITS-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d;
    logic [4*DIGITS-1:0] pnd_data_q, pnd_data_d;
    logic [DIGITS-1:0]   pnd_blank_q, pnd_blank_d;
    logic                pnd_full_q, pnd_full_d;
    logic [3:0]          nib_q, nib_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic                fs_q, fs_d;
    logic                bound;
    logic                accept;

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        dig_d       = dig_q;
        act_data_d  = act_data_q;
        act_blank_d = act_blank_q;
        pnd_data_d  = pnd_data_q;
        pnd_blank_d = pnd_blank_q;
        pnd_full_d  = pnd_full_q;
        nib_d       = nib_q;
        sel_d       = '1;
        bound       = 1'b0;
        accept      = wr.wr_valid && !pnd_full_q;

        // Counters describe the slot position that the registered outputs show.
        unique case (state_q)
            ST_IDLE: begin
                slot_d = '0;
                dig_d  = '0;
                if (en) begin
                    state_d = ST_SCAN;
                    bound   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    dig_d   = '0;
                end else if (slot_q == SW'(DIV - 1)) begin
                    slot_d = '0;
                    if (dig_q == DW'(DIGITS - 1)) begin
                        dig_d = '0;
                        bound = 1'b1;
                    end else begin
                        dig_d = dig_q + 1'b1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bound && pnd_full_q) begin
            act_data_d  = pnd_data_q;
            act_blank_d = pnd_blank_q;
            pnd_full_d  = 1'b0;
        end

        if (accept) begin
            pnd_data_d  = wr.wr_data;
            pnd_blank_d = wr.wr_blank;
            pnd_full_d  = 1'b1;
        end

        // Digit goes dark during the dead window so the decoder settles first.
        for (int i = 0; i < DIGITS; i++) begin
            if (DW'(i) == dig_d) begin
                nib_d = act_data_d[4*i +: 4];
                if (en && slot_d >= SW'(DEAD) && !act_blank_d[i]) begin
                    sel_d[i] = 1'b0;
                end
            end
        end

        fs_d = bound;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            dig_q       <= '0;
            act_data_q  <= '0;
            act_blank_q <= '1;
            pnd_data_q  <= '0;
            pnd_blank_q <= '0;
            pnd_full_q  <= 1'b0;
            nib_q       <= '0;
            sel_q       <= '1;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            dig_q       <= dig_d;
            act_data_q  <= act_data_d;
            act_blank_q <= act_blank_d;
            pnd_data_q  <= pnd_data_d;
            pnd_blank_q <= pnd_blank_d;
            pnd_full_q  <= pnd_full_d;
            nib_q       <= nib_d;
            sel_q       <= sel_d;
            fs_q        <= fs_d;
        end
    end

    assign wr.wr_ready  = !pnd_full_q;
    assign nib_out      = nib_q;
    assign dig_sel      = sel_q;
    assign frame_start  = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic
// checked against a time-based model of the scan and double buffer.
module tb_seg_scan_ctrl;
    localparam int DIGITS = 4;
    localparam int DIV    = 16;
    localparam int DEAD   = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] nib_out;
    logic [3:0] dig_sel;
    logic       frame_start;

    seg_scan_if #(.DIGITS(DIGITS)) wif ();

    seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .DEAD  (DEAD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr         (wif.slave),
        .nib_out    (nib_out),
        .dig_sel    (dig_sel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_t counts clocks since scanning (re)started, -1 when stopped.
    int          m_t;
    logic [15:0] m_act, m_pnd;
    logic [3:0]  m_ablank, m_pblank;
    logic        m_full, m_acc, m_fs;
    logic [3:0]  x_nib, x_sel;
    logic        x_fs, x_rdy;

    function automatic void expect_now();
        int dig, slot;
        if (m_t >= 0) begin
            dig   = (m_t / DIV) % DIGITS;
            slot  = m_t % DIV;
            x_nib = 4'((m_act >> (4 * dig)) & 16'hF);
            if (slot >= DEAD && !m_ablank[dig]) x_sel = ~(4'b0001 << dig);
            else x_sel = 4'hF;
        end else begin
            x_nib = m_act[3:0];
            x_sel = 4'hF;
        end
        x_fs  = m_fs;
        x_rdy = !m_full;
    endfunction

    task automatic model_reset();
        m_t = -1; m_act = '0; m_ablank = '1;
        m_pnd = '0; m_pblank = '0;
        m_full = 1'b0; m_acc = 1'b0; m_fs = 1'b0;
        expect_now();
    endtask

    task automatic tick(input logic e, input logic v,
                        input logic [15:0] d, input logic [3:0] b);
        logic acc;
        en = e; wif.wr_valid = v; wif.wr_data = d; wif.wr_blank = b;
        @(posedge clk);
        acc = v && !m_full;
        if (e) m_t = (m_t < 0) ? 0 : m_t + 1;
        else m_t = -1;
        m_fs = e && (m_t % FRAME == 0);
        if (m_fs && m_full) begin
            m_act = m_pnd; m_ablank = m_pblank; m_full = 1'b0;
        end
        if (acc) begin
            m_pnd = d; m_pblank = b; m_full = 1'b1;
        end
        m_acc = acc;
        expect_now();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        wif.wr_valid = 1'b0; wif.wr_data = '0; wif.wr_blank = '0;
        model_reset();
        @(posedge clk); #1;
        checks += 4;
        if (dig_sel !== 4'hF) begin errors++; $display("FAIL reset_sel got %h exp %h", dig_sel, 4'hF); end
        if (nib_out !== 4'h0) begin errors++; $display("FAIL reset_nib got %h exp %h", nib_out, 4'h0); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start); end
        if (wif.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", wif.wr_ready); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int c = 0; c <= 2 * FRAME; c++) begin
            tick(1'b1, 1'b0, 16'h0, 4'h0);
            checks += 2;
            if (dig_sel !== 4'hF) begin errors++; $display("FAIL idle_sel c=%0d got %h exp %h", c, dig_sel, 4'hF); end
            if (frame_start !== ((c % FRAME) == 0)) begin
                errors++; $display("FAIL idle_fs c=%0d got %b exp %b", c, frame_start, (c % FRAME) == 0);
            end
        end
    endtask

    task automatic test_digits();
        logic hold = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick(1'b1, hold, 16'h3A5F, 4'h0);
            if (m_acc) hold = 1'b0;
            checks += 2;
            if (nib_out !== x_nib) begin errors++; $display("FAIL digits_nib t=%0d got %h exp %h", m_t, nib_out, x_nib); end
            if (dig_sel !== x_sel) begin errors++; $display("FAIL digits_sel t=%0d got %b exp %b", m_t, dig_sel, x_sel); end
        end
        checks++;
        if (hold) begin errors++; $display("FAIL digits_accept got none exp accepted"); end
    endtask

    task automatic test_back_to_back();
        logic hold2 = 1'b1;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 20; c++) tick(1'b1, 1'b0, 16'h0, 4'h0);
        tick(1'b1, 1'b1, 16'h1111, 4'h0);
        checks++;
        if (wif.wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_rdy_low got %b exp 0", wif.wr_ready); end
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick(1'b1, hold2, 16'h2222, 4'h0);
            if (m_acc) hold2 = 1'b0;
            checks += 3;
            if (wif.wr_ready !== x_rdy) begin errors++; $display("FAIL b2b_rdy t=%0d got %b exp %b", m_t, wif.wr_ready, x_rdy); end
            if (nib_out !== x_nib) begin errors++; $display("FAIL b2b_nib t=%0d got %h exp %h", m_t, nib_out, x_nib); end
            if (frame_start !== x_fs) begin errors++; $display("FAIL b2b_fs t=%0d got %b exp %b", m_t, frame_start, x_fs); end
        end
        checks++;
        if (hold2) begin errors++; $display("FAIL b2b_second got none exp accepted"); end
    endtask

    task automatic test_blank();
        logic hold = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick(1'b1, hold, 16'h8421, 4'b0101);
            if (m_acc) hold = 1'b0;
            checks++;
            if (dig_sel !== x_sel) begin errors++; $display("FAIL blank_sel t=%0d got %b exp %b", m_t, dig_sel, x_sel); end
        end
    endtask

    task automatic test_boundary();
        logic [3:0] old_nib;
        for (int c = 0; c < FRAME && (m_t % FRAME) != FRAME - 1; c++) tick(1'b1, 1'b0, 16'h0, 4'h0);
        old_nib = m_act[3:0];
        tick(1'b1, 1'b1, 16'hBEEF, 4'h0);
        checks += 3;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL bnd_fs got %b exp 1", frame_start); end
        if (nib_out !== old_nib) begin errors++; $display("FAIL bnd_old got %h exp %h", nib_out, old_nib); end
        if (wif.wr_ready !== 1'b0) begin errors++; $display("FAIL bnd_rdy got %b exp 0", wif.wr_ready); end
        for (int c = 0; c < FRAME; c++) begin
            tick(1'b1, 1'b0, 16'h0, 4'h0);
            checks++;
            if (nib_out !== x_nib) begin errors++; $display("FAIL bnd_nib t=%0d got %h exp %h", m_t, nib_out, x_nib); end
        end
        checks += 2;
        if (frame_start !== 1'b1) begin errors++; $display("FAIL bnd_next_fs got %b exp 1", frame_start); end
        if (nib_out !== 4'hF) begin errors++; $display("FAIL bnd_new got %h exp %h", nib_out, 4'hF); end
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 2 * FRAME && !((m_t / DIV) % DIGITS == 2 && m_t % DIV == 5); c++)
            tick(1'b1, 1'b0, 16'h0, 4'h0);
        rst = 1'b1;
        model_reset();
        #1;
        checks += 4;
        if (dig_sel !== x_sel) begin errors++; $display("FAIL rst_sel got %b exp %b", dig_sel, x_sel); end
        if (nib_out !== x_nib) begin errors++; $display("FAIL rst_nib got %h exp %h", nib_out, x_nib); end
        if (frame_start !== x_fs) begin errors++; $display("FAIL rst_fs got %b exp %b", frame_start, x_fs); end
        if (wif.wr_ready !== x_rdy) begin errors++; $display("FAIL rst_rdy got %b exp %b", wif.wr_ready, x_rdy); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < FRAME + 6; c++) begin
            tick(1'b1, c == 3, 16'h5678, 4'h0);
            checks += 3;
            if (dig_sel !== x_sel) begin errors++; $display("FAIL rst_run_sel t=%0d got %b exp %b", m_t, dig_sel, x_sel); end
            if (nib_out !== x_nib) begin errors++; $display("FAIL rst_run_nib t=%0d got %h exp %h", m_t, nib_out, x_nib); end
            if (frame_start !== x_fs) begin errors++; $display("FAIL rst_run_fs t=%0d got %b exp %b", m_t, frame_start, x_fs); end
        end
    endtask

    task automatic test_en_gap();
        for (int c = 0; c < DIV && (m_t % DIV) != 7; c++) tick(1'b1, 1'b0, 16'h0, 4'h0);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b0, 16'h0, 4'h0);
            checks += 3;
            if (dig_sel !== 4'hF) begin errors++; $display("FAIL gap_sel c=%0d got %b exp 1111", c, dig_sel); end
            if (frame_start !== 1'b0) begin errors++; $display("FAIL gap_fs c=%0d got %b exp 0", c, frame_start); end
            if (nib_out !== x_nib) begin errors++; $display("FAIL gap_nib c=%0d got %h exp %h", c, nib_out, x_nib); end
        end
        for (int c = 0; c < DIV + 4; c++) begin
            tick(1'b1, 1'b0, 16'h0, 4'h0);
            checks += 2;
            if (frame_start !== (c == 0)) begin errors++; $display("FAIL reen_fs c=%0d got %b exp %b", c, frame_start, c == 0); end
            if (dig_sel !== x_sel) begin errors++; $display("FAIL reen_sel c=%0d got %b exp %b", c, dig_sel, x_sel); end
        end
    endtask

    task automatic test_random();
        logic        hv = 1'b0;
        logic [15:0] hd = '0;
        logic [3:0]  hb = '0;
        logic        e;
        int          off = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!hv && $urandom_range(0, 3) == 0) begin
                hv = 1'b1; hd = 16'($urandom); hb = 4'($urandom);
            end
            if (off > 0) begin e = 1'b0; off--; end
            else if ($urandom_range(0, 199) == 0) begin e = 1'b0; off = $urandom_range(0, 5); end
            else e = 1'b1;
            tick(e, hv, hd, hb);
            if (m_acc) hv = 1'b0;
            checks += 4;
            if (nib_out !== x_nib) begin errors++; $display("FAIL rnd_nib c=%0d got %h exp %h", c, nib_out, x_nib); end
            if (dig_sel !== x_sel) begin errors++; $display("FAIL rnd_sel c=%0d got %b exp %b", c, dig_sel, x_sel); end
            if (frame_start !== x_fs) begin errors++; $display("FAIL rnd_fs c=%0d got %b exp %b", c, frame_start, x_fs); end
            if (wif.wr_ready !== x_rdy) begin errors++; $display("FAIL rnd_rdy c=%0d got %b exp %b", c, wif.wr_ready, x_rdy); end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_digits();
        test_back_to_back();
        test_blank();
        test_boundary();
        test_rst_mid();
        test_en_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-cathode seven-segment digits. Holds a DIGITS-nibble display value plus a per-digit blank mask, steps through the digits at a programmable slot rate, and feeds one nibble at a time to the registered hex-to-segment decoder. Drives the active-low digit enables with a dead-time window that absorbs the decoder's one-cycle latency and prevents ghosting. New values arrive over a valid/ready handshake and are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; must be ≥ 2.
- DIV, 1000: clocks per digit slot; must be > DEAD.
- DEAD, 8: clocks at the start of each slot with all digits off; must be ≥ 2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  scan enable; when 0, all digits are off and the scan counters are held at zero.
- wr_valid  in  1  a new display value is offered.
- wr_ready  out  1  the controller can accept a value (the pending shadow is empty).
- wr_data  in  4*DIGITS  nibble for digit i in [4i+3:4i].
- wr_blank  in  DIGITS  bit i = 1 keeps digit i dark.
- nib_out  out  4  nibble to the segment decoder.
- dig_sel  out  DIGITS  active-low, one-hot digit enable; all-ones means every digit is off.
- frame_start  out  1  one-cycle pulse in slot cycle 0 of digit 0.

## Operation
- Registers:
  - Active value and mask: act_data, act_blank.
  - Pending shadow: pnd_data, pnd_blank, pnd_full.
  - Counters: slot_cnt (0..DIV-1) and dig_idx (0..DIGITS-1).
- Reset values:
  - act_data = 0, act_blank = all ones, pnd_full = 0.
  - Both counters 0.
  - dig_sel = all ones, nib_out = 0, frame_start = 0, wr_ready = 1.
- Handshake:
  - wr_ready = !pnd_full.
  - Transfer occurs when wr_valid && wr_ready; wr_data and wr_blank are latched into the shadow and pnd_full is set.
  - wr_valid while wr_ready = 0 is ignored; the source must hold its value.
  - Handshake works regardless of en.
- Scan, en = 1:
  - slot_cnt increments each clock and wraps DIV-1 → 0.
  - On that wrap, dig_idx increments and wraps DIGITS-1 → 0.
  - Sequence of digit slots: 0, 1, …, DIGITS-1, 0, …
- Within a slot for digit i:
  - nib_out = act_data[4i+3:4i] for the whole slot.
  - dig_sel = all ones for slot cycles 0..DEAD-1.
  - For slot cycles DEAD..DIV-1, dig_sel[i] = 0 and all other bits = 1, unless act_blank[i] = 1, in which case dig_sel stays all ones.
- Frame boundary (entering slot cycle 0 of digit 0, from the scan wrap or from en = 0 → 1):
  - If pnd_full, copy the shadow into act_* and clear pnd_full.
  - A write accepted in the same cycle as the boundary goes into the shadow and is applied at the next boundary.
- en = 0:
  - Counters forced to 0; dig_sel all ones, frame_start 0; nib_out holds digit 0.
  - The act_* and shadow registers are retained.
- Reset mid-frame: everything returns to reset values immediately; no partial state survives.

## Timing
- All outputs are registered.
- Output cycle numbering: the first clock after rst deasserts with en = 1 is observed as digit 0, slot cycle 0, with frame_start = 1.
- Frame length: DIGITS × DIV clocks; frame_start period is exactly DIGITS × DIV.
- Latency from write acceptance to display: the value becomes visible on nib_out at the next frame boundary, at most DIGITS × DIV clocks later.
- The digit becomes lit DEAD clocks after nib_out changes, which covers the decoder's 1-cycle latency plus margin.
- wr_ready:
  - Falls the cycle after acceptance.
  - Rises the cycle after the boundary that consumes the shadow.
- en 1 → 0: dig_sel is all ones on the next clock.
- en 0 → 1: frame_start fires on the first enabled clock.

## Test plan
Parameters for all scenarios: DIGITS = 4, DIV = 16, DEAD = 2.
- Reset, then en = 1 with no write: dig_sel stays 4'b1111 for 128 clocks; frame_start pulses at cycles 0, 64, 128.
- Write wr_data = 16'h3A5F, wr_blank = 0:
  - The next frame shows nib_out F, 5, A, 3 in successive 16-clock slots.
  - dig_sel is 1110 / 1101 / 1011 / 0111 during slot cycles 2..15 and 1111 during cycles 0..1.
- Two back-to-back writes (16'h1111, then 16'h2222) mid-frame:
  - wr_ready = 0 after the first; the second is stalled.
  - At the boundary 1111 is displayed and wr_ready rises.
  - The second write is accepted and displayed one frame later.
- Write with wr_blank = 4'b0101: digits 0 and 2 keep dig_sel all ones for their whole slots; digits 1 and 3 light normally.
- Write accepted in the exact boundary cycle: the old value is shown for that frame; the new value appears at the following frame_start.
- Assert rst for 1 cycle in the slot for digit 2, and separately drop en mid-slot for 5 cycles:
  - rst: outputs return to reset values immediately; the scan restarts at digit 0.
  - en: dig_sel is 1111 during the gap; frame_start pulses on re-enable.
